// File: rtl/fp_cmp_pipe_if.sv
// Issue/result bundle for the pipelined FP compare unit.
// start issues one op per cycle with no ready; done pulses exactly two cycles later per accepted op.
interface fp_cmp_pipe_if #(
   parameter int DATA_W = 32
) ();
   logic              start;
   logic [2:0]        fn;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              clr_flags;
   logic              done;
   logic [DATA_W-1:0] res;
   logic              nv;
   logic              nv_sticky;

   modport master (
      output start, fn, op_a, op_b, clr_flags,
      input  done, res, nv, nv_sticky
   );

   modport slave (
      input  start, fn, op_a, op_b, clr_flags,
      output done, res, nv, nv_sticky
   );
endinterface

// File: rtl/fp_cmp_pipe.sv
// Two-stage IEEE-754 compare / min-max / classify unit.
// Stage 1 decodes operand classes and magnitude order; stage 2 selects the result and invalid flag.
module fp_cmp_pipe #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8
) (
   input logic          clk,
   input logic          rst,
   fp_cmp_pipe_if.slave bus
);
   localparam int MAN_W = DATA_W - EXP_W - 1;

   localparam logic [2:0] FN_LE  = 3'd0;
   localparam logic [2:0] FN_LT  = 3'd1;
   localparam logic [2:0] FN_EQ  = 3'd2;
   localparam logic [2:0] FN_MIN = 3'd3;
   localparam logic [2:0] FN_MAX = 3'd4;
   localparam logic [2:0] FN_CLS = 3'd5;

   localparam logic [DATA_W-1:0] CANON_NAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic exp_ones(input logic [DATA_W-1:0] x);
      return &x[DATA_W-2 -: EXP_W];
   endfunction
   function automatic logic exp_zero(input logic [DATA_W-1:0] x);
      return ~|x[DATA_W-2 -: EXP_W];
   endfunction
   function automatic logic man_zero(input logic [DATA_W-1:0] x);
      return ~|x[MAN_W-1:0];
   endfunction

   // Stage 1 registers
   logic              v1_q, v1_d;
   logic [2:0]        fn1_q, fn1_d;
   logic [DATA_W-1:0] a1_q, a1_d, b1_q, b1_d;
   logic              a_zero_q, a_zero_d, a_sub_q, a_sub_d, a_inf_q, a_inf_d;
   logic              a_qnan_q, a_qnan_d, a_snan_q, a_snan_d;
   logic              b_zero_q, b_zero_d, b_qnan_q, b_qnan_d, b_snan_q, b_snan_d;
   logic              mag_lt_q, mag_lt_d, mag_eq_q, mag_eq_d;

   // Stage 2 / output registers
   logic              done_q, done_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              nv_q, nv_d;
   logic              sticky_q, sticky_d;

   always_comb begin
      v1_d     = bus.start;
      fn1_d    = fn1_q;
      a1_d     = a1_q;
      b1_d     = b1_q;
      a_zero_d = a_zero_q;
      a_sub_d  = a_sub_q;
      a_inf_d  = a_inf_q;
      a_qnan_d = a_qnan_q;
      a_snan_d = a_snan_q;
      b_zero_d = b_zero_q;
      b_qnan_d = b_qnan_q;
      b_snan_d = b_snan_q;
      mag_lt_d = mag_lt_q;
      mag_eq_d = mag_eq_q;
      if (bus.start) begin
         fn1_d    = bus.fn;
         a1_d     = bus.op_a;
         b1_d     = bus.op_b;
         a_zero_d = exp_zero(bus.op_a) & man_zero(bus.op_a);
         a_sub_d  = exp_zero(bus.op_a) & ~man_zero(bus.op_a);
         a_inf_d  = exp_ones(bus.op_a) & man_zero(bus.op_a);
         a_qnan_d = exp_ones(bus.op_a) & bus.op_a[MAN_W-1];
         a_snan_d = exp_ones(bus.op_a) & ~bus.op_a[MAN_W-1] & ~man_zero(bus.op_a);
         b_zero_d = exp_zero(bus.op_b) & man_zero(bus.op_b);
         b_qnan_d = exp_ones(bus.op_b) & bus.op_b[MAN_W-1];
         b_snan_d = exp_ones(bus.op_b) & ~bus.op_b[MAN_W-1] & ~man_zero(bus.op_b);
         mag_lt_d = bus.op_a[DATA_W-2:0] <  bus.op_b[DATA_W-2:0];
         mag_eq_d = bus.op_a[DATA_W-2:0] == bus.op_b[DATA_W-2:0];
      end
   end

   logic              sa, sb, a_nan, b_nan, any_snan, both_zero;
   logic              equal, less, a_first;
   logic [DATA_W-1:0] min_v, max_v, res_n;
   logic [9:0]        cls;
   logic              nv_n;

   always_comb begin
      sa        = a1_q[DATA_W-1];
      sb        = b1_q[DATA_W-1];
      a_nan     = a_qnan_q | a_snan_q;
      b_nan     = b_qnan_q | b_snan_q;
      any_snan  = a_snan_q | b_snan_q;
      both_zero = a_zero_q & b_zero_q;
      equal     = both_zero | ((sa == sb) & mag_eq_q);
      if (both_zero)      less = 1'b0;
      else if (sa != sb)  less = sa;
      else if (!sa)       less = mag_lt_q;
      else                less = ~mag_lt_q & ~mag_eq_q;
      // Total order for MIN/MAX additionally puts -0 below +0.
      a_first = less | (both_zero & sa & ~sb);

      if (a_nan & b_nan) begin
         min_v = CANON_NAN;
         max_v = CANON_NAN;
      end else if (a_nan) begin
         min_v = b1_q;
         max_v = b1_q;
      end else if (b_nan) begin
         min_v = a1_q;
         max_v = a1_q;
      end else begin
         min_v = a_first ? a1_q : b1_q;
         max_v = a_first ? b1_q : a1_q;
      end

      cls[0] = a_inf_q & sa;
      cls[1] = ~a_inf_q & ~a_nan & ~a_zero_q & ~a_sub_q & sa;
      cls[2] = a_sub_q & sa;
      cls[3] = a_zero_q & sa;
      cls[4] = a_zero_q & ~sa;
      cls[5] = a_sub_q & ~sa;
      cls[6] = ~a_inf_q & ~a_nan & ~a_zero_q & ~a_sub_q & ~sa;
      cls[7] = a_inf_q & ~sa;
      cls[8] = a_snan_q;
      cls[9] = a_qnan_q;

      res_n = '0;
      nv_n  = 1'b0;
      case (fn1_q)
         FN_LE: begin
            res_n[0] = ~(a_nan | b_nan) & (less | equal);
            nv_n     = a_nan | b_nan;
         end
         FN_LT: begin
            res_n[0] = ~(a_nan | b_nan) & less;
            nv_n     = a_nan | b_nan;
         end
         FN_EQ: begin
            res_n[0] = ~(a_nan | b_nan) & equal;
            nv_n     = any_snan;
         end
         FN_MIN: begin
            res_n = min_v;
            nv_n  = any_snan;
         end
         FN_MAX: begin
            res_n = max_v;
            nv_n  = any_snan;
         end
         FN_CLS:  res_n = {{(DATA_W-10){1'b0}}, cls};
         default: res_n = '0;
      endcase

      done_d   = v1_q;
      res_d    = v1_q ? res_n : res_q;
      nv_d     = v1_q ? nv_n  : nv_q;
      // A completing invalid op beats a coincident clear.
      sticky_d = (sticky_q & ~bus.clr_flags) | (done_q & nv_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q     <= 1'b0;
         fn1_q    <= '0;
         a1_q     <= '0;
         b1_q     <= '0;
         a_zero_q <= 1'b0;
         a_sub_q  <= 1'b0;
         a_inf_q  <= 1'b0;
         a_qnan_q <= 1'b0;
         a_snan_q <= 1'b0;
         b_zero_q <= 1'b0;
         b_qnan_q <= 1'b0;
         b_snan_q <= 1'b0;
         mag_lt_q <= 1'b0;
         mag_eq_q <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
         nv_q     <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         fn1_q    <= fn1_d;
         a1_q     <= a1_d;
         b1_q     <= b1_d;
         a_zero_q <= a_zero_d;
         a_sub_q  <= a_sub_d;
         a_inf_q  <= a_inf_d;
         a_qnan_q <= a_qnan_d;
         a_snan_q <= a_snan_d;
         b_zero_q <= b_zero_d;
         b_qnan_q <= b_qnan_d;
         b_snan_q <= b_snan_d;
         mag_lt_q <= mag_lt_d;
         mag_eq_q <= mag_eq_d;
         done_q   <= done_d;
         res_q    <= res_d;
         nv_q     <= nv_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.done      = done_q;
   assign bus.res       = res_q;
   assign bus.nv        = nv_q;
   assign bus.nv_sticky = sticky_q | (done_q & nv_q);
endmodule
